// File: rtl/regfile_pkg.sv
// Shared constants and the clear-sweep state encoding for the register file.
package regfile_pkg;

   // Default datapath sizing, shared with the decode and ALU blocks
   localparam int unsigned REGFILE_WIDTH  = 8;
   localparam int unsigned REGFILE_ADDR_W = 2;

   // Bulk-clear sequencer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } sweep_state_e;

endpackage : regfile_pkg

// File: rtl/regfile_clear_fsm.sv
// Bulk-clear sequencer: walks idx over every register, flags Busy/Done,
// and decides whether a user write may be accepted this cycle.
module regfile_clear_fsm
   import regfile_pkg::*;
#(
   parameter int unsigned ADDR_W = REGFILE_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              reg_write,
   output logic              busy,
   output logic              done,
   output logic              sweep_we_c,
   output logic [ADDR_W-1:0] sweep_idx_c,
   output logic              wr_accept_c
);

   localparam int unsigned       DEPTH    = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   sweep_state_e      state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;

   // State, sweep index and registered Busy/Done flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         busy    <= (state_d == SWEEP);
         done    <= (state_d == DONE);
      end
   end

   // Next state, sweep stepping and user-write acceptance
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      sweep_we_c  = 1'b0;
      wr_accept_c = 1'b0;
      unique case (state_q)
         IDLE: begin
            wr_accept_c = reg_write;
            if (clear) begin
               state_d = SWEEP;
               idx_d   = '0;
            end
         end
         SWEEP: begin
            // User writes are dropped while the sweep owns the write port
            sweep_we_c = 1'b1;
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + ADDR_W'(1);
            end
         end
         DONE: begin
            wr_accept_c = reg_write;
            state_d     = IDLE;
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   assign sweep_idx_c = idx_q;

endmodule : regfile_clear_fsm

// File: rtl/regfile_param.sv
// Parametrised two-read/one-write register file with optional hardwired
// zero register, write-to-read bypass and a sequenced bulk clear.
module regfile_param
   import regfile_pkg::*;
#(
   parameter int unsigned WIDTH    = REGFILE_WIDTH,
   parameter int unsigned ADDR_W   = REGFILE_ADDR_W,
   parameter bit          ZERO_REG = 1'b0,
   parameter bit          BYPASS   = 1'b1
) (
   input  logic              clk,
   input  logic              Reset_n,
   input  logic              RegWrite,
   input  logic [ADDR_W-1:0] Read1,
   input  logic [ADDR_W-1:0] Read2,
   input  logic [ADDR_W-1:0] WriteR,
   input  logic [WIDTH-1:0]  WriteD,
   output logic [WIDTH-1:0]  ReadD1,
   output logic [WIDTH-1:0]  ReadD2,
   input  logic              Clear,
   output logic              Busy,
   output logic              Done
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [WIDTH-1:0]  regs_q [DEPTH];
   logic              sweep_we_c;
   logic [ADDR_W-1:0] sweep_idx_c;
   logic              wr_accept_c;
   logic              user_wr_c;
   logic              wr_en_c;
   logic [ADDR_W-1:0] wr_addr_c;
   logic [WIDTH-1:0]  wr_data_c;

   regfile_clear_fsm #(
      .ADDR_W (ADDR_W)
   ) u_clear_fsm (
      .clk         (clk),
      .rst_n       (Reset_n),
      .clear       (Clear),
      .reg_write   (RegWrite),
      .busy        (Busy),
      .done        (Done),
      .sweep_we_c  (sweep_we_c),
      .sweep_idx_c (sweep_idx_c),
      .wr_accept_c (wr_accept_c)
   );

   // A user write is real only if accepted and not aimed at a hardwired zero
   assign user_wr_c = wr_accept_c && !(ZERO_REG && (WriteR == '0));

   // Single write port: sweep zero-writes and user writes never overlap
   always_comb begin
      wr_en_c   = 1'b0;
      wr_addr_c = WriteR;
      wr_data_c = WriteD;
      if (sweep_we_c) begin
         wr_en_c   = 1'b1;
         wr_addr_c = sweep_idx_c;
         wr_data_c = '0;
      end else if (user_wr_c) begin
         wr_en_c = 1'b1;
      end
   end

   // Storage, one flop row per address behind the write-address decoder
   for (genvar g = 0; g < DEPTH; g++) begin : g_row
      always_ff @(posedge clk or negedge Reset_n) begin
         if (!Reset_n) begin
            regs_q[g] <= '0;
         end else if (wr_en_c && (wr_addr_c == ADDR_W'(g))) begin
            regs_q[g] <= wr_data_c;
         end
      end
   end

   // Combinational reads with optional bypass; register 0 may be forced to zero
   always_comb begin
      ReadD1 = regs_q[Read1];
      ReadD2 = regs_q[Read2];
      if (BYPASS && user_wr_c && (WriteR == Read1)) ReadD1 = WriteD;
      if (BYPASS && user_wr_c && (WriteR == Read2)) ReadD2 = WriteD;
      if (ZERO_REG && (Read1 == '0)) ReadD1 = '0;
      if (ZERO_REG && (Read2 == '0)) ReadD2 = '0;
   end

endmodule : regfile_param

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: three 8-bit variants share stimulus
// (bypass, no bypass, zero register), plus a 16-bit x 8 instance.
module tb_regfile_param;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       reg_write;
   logic [1:0] read1, read2, write_r;
   logic [7:0] write_d;
   logic       clear;

   logic [7:0] a_rd1, a_rd2, b_rd1, b_rd2, z_rd1, z_rd2;
   logic       a_busy, a_done, b_busy, b_done, z_busy, z_done;

   logic        w_we, w_clear, w_busy, w_done;
   logic [2:0]  w_r1, w_r2, w_wr;
   logic [15:0] w_wd, w_rd1, w_rd2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   regfile_param #(.WIDTH(8), .ADDR_W(2), .ZERO_REG(1'b0), .BYPASS(1'b1)) u_a (
      .clk(clk), .Reset_n(rst_n), .RegWrite(reg_write), .Read1(read1), .Read2(read2),
      .WriteR(write_r), .WriteD(write_d), .ReadD1(a_rd1), .ReadD2(a_rd2),
      .Clear(clear), .Busy(a_busy), .Done(a_done));

   regfile_param #(.WIDTH(8), .ADDR_W(2), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_b (
      .clk(clk), .Reset_n(rst_n), .RegWrite(reg_write), .Read1(read1), .Read2(read2),
      .WriteR(write_r), .WriteD(write_d), .ReadD1(b_rd1), .ReadD2(b_rd2),
      .Clear(clear), .Busy(b_busy), .Done(b_done));

   regfile_param #(.WIDTH(8), .ADDR_W(2), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_z (
      .clk(clk), .Reset_n(rst_n), .RegWrite(reg_write), .Read1(read1), .Read2(read2),
      .WriteR(write_r), .WriteD(write_d), .ReadD1(z_rd1), .ReadD2(z_rd2),
      .Clear(clear), .Busy(z_busy), .Done(z_done));

   regfile_param #(.WIDTH(16), .ADDR_W(3), .ZERO_REG(1'b0), .BYPASS(1'b1)) u_w (
      .clk(clk), .Reset_n(rst_n), .RegWrite(w_we), .Read1(w_r1), .Read2(w_r2),
      .WriteR(w_wr), .WriteD(w_wd), .ReadD1(w_rd1), .ReadD2(w_rd2),
      .Clear(w_clear), .Busy(w_busy), .Done(w_done));

   typedef struct packed {
      logic       we;
      logic [1:0] wr;
      logic [7:0] wd;
      logic [1:0] r1;
      logic [1:0] r2;
      logic [7:0] a1, a2, b1, b2, z1, z2;
   } vec_t;

   typedef struct packed {
      logic       we;
      logic [1:0] wr;
      logic [7:0] wd;
      logic [1:0] r1;
      logic [1:0] r2;
      logic [7:0] e1, e2;
      logic       busy;
      logic       done;
   } swp_t;

   vec_t vecs [8];
   swp_t swps [6];
   logic [7:0] fill [4];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      int busy_cnt;
      int done_cnt;
      int done_at;

      //               we    wr    wd     r1    r2    a1     a2     b1     b2     z1     z2
      vecs[0] = '{1'b1, 2'd1, 8'hA5, 2'd1, 2'd2, 8'hA5, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h00};
      vecs[1] = '{1'b1, 2'd2, 8'h3C, 2'd1, 2'd2, 8'hA5, 8'h3C, 8'hA5, 8'h00, 8'hA5, 8'h3C};
      vecs[2] = '{1'b0, 2'd0, 8'h00, 2'd1, 2'd2, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
      vecs[3] = '{1'b1, 2'd3, 8'h7E, 2'd3, 2'd0, 8'h7E, 8'h00, 8'h00, 8'h00, 8'h7E, 8'h00};
      vecs[4] = '{1'b1, 2'd0, 8'hFF, 2'd0, 2'd3, 8'hFF, 8'h7E, 8'h00, 8'h7E, 8'h00, 8'h7E};
      vecs[5] = '{1'b0, 2'd0, 8'h00, 2'd0, 2'd3, 8'hFF, 8'h7E, 8'hFF, 8'h7E, 8'h00, 8'h7E};
      vecs[6] = '{1'b1, 2'd1, 8'h5A, 2'd1, 2'd1, 8'h5A, 8'h5A, 8'hA5, 8'hA5, 8'h5A, 8'h5A};
      vecs[7] = '{1'b0, 2'd0, 8'h00, 2'd1, 2'd0, 8'h5A, 8'hFF, 8'h5A, 8'hFF, 8'h5A, 8'h00};

      // Cycles after the Clear edge on u_a, registers preloaded with fill[]
      //               we    wr    wd     r1    r2    e1     e2     busy  done
      swps[0] = '{1'b0, 2'd0, 8'h00, 2'd0, 2'd1, 8'h11, 8'h22, 1'b1, 1'b0};
      swps[1] = '{1'b1, 2'd2, 8'h55, 2'd0, 2'd2, 8'h00, 8'h33, 1'b1, 1'b0};
      swps[2] = '{1'b0, 2'd0, 8'h00, 2'd1, 2'd2, 8'h00, 8'h33, 1'b1, 1'b0};
      swps[3] = '{1'b0, 2'd0, 8'h00, 2'd2, 2'd3, 8'h00, 8'h44, 1'b1, 1'b0};
      swps[4] = '{1'b1, 2'd1, 8'h99, 2'd3, 2'd1, 8'h00, 8'h99, 1'b0, 1'b1};
      swps[5] = '{1'b0, 2'd0, 8'h00, 2'd3, 2'd1, 8'h00, 8'h99, 1'b0, 1'b0};

      fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;

      rst_n = 1'b0; reg_write = 1'b0; read1 = '0; read2 = '0; write_r = '0;
      write_d = '0; clear = 1'b0;
      w_we = 1'b0; w_clear = 1'b0; w_r1 = '0; w_r2 = '0; w_wr = '0; w_wd = '0;
      #12;
      rst_n = 1'b1;

      // Reset state
      for (int i = 0; i < 4; i++) begin
         read1 = 2'(i);
         read2 = 2'(3 - i);
         #1;
         chk("reset_rd1", 16'(a_rd1), 16'h0000);
         chk("reset_rd2", 16'(a_rd2), 16'h0000);
      end
      chk("reset_busy", 16'(a_busy), 16'h0000);
      chk("reset_done", 16'(a_done), 16'h0000);
      chk("reset_w_busy", 16'(w_busy), 16'h0000);
      cyc();

      // Table: basic writes, bypass vs no bypass, hardwired zero
      for (int i = 0; i < 8; i++) begin
         reg_write = vecs[i].we;
         write_r   = vecs[i].wr;
         write_d   = vecs[i].wd;
         read1     = vecs[i].r1;
         read2     = vecs[i].r2;
         #1;
         chk($sformatf("vec%0d_a_rd1", i), 16'(a_rd1), 16'(vecs[i].a1));
         chk($sformatf("vec%0d_a_rd2", i), 16'(a_rd2), 16'(vecs[i].a2));
         chk($sformatf("vec%0d_b_rd1", i), 16'(b_rd1), 16'(vecs[i].b1));
         chk($sformatf("vec%0d_b_rd2", i), 16'(b_rd2), 16'(vecs[i].b2));
         chk($sformatf("vec%0d_z_rd1", i), 16'(z_rd1), 16'(vecs[i].z1));
         chk($sformatf("vec%0d_z_rd2", i), 16'(z_rd2), 16'(vecs[i].z2));
         cyc();
      end

      // Preload, then one Clear pulse with a dropped mid-sweep write
      for (int k = 0; k < 4; k++) begin
         reg_write = 1'b1;
         write_r   = 2'(k);
         write_d   = fill[k];
         cyc();
      end
      reg_write = 1'b0;
      clear     = 1'b1;
      #1;
      chk("sweep_pre_busy", 16'(a_busy), 16'h0000);
      cyc();
      clear = 1'b0;
      for (int c = 0; c < 6; c++) begin
         reg_write = swps[c].we;
         write_r   = swps[c].wr;
         write_d   = swps[c].wd;
         read1     = swps[c].r1;
         read2     = swps[c].r2;
         #1;
         chk($sformatf("sweep%0d_rd1", c + 1), 16'(a_rd1), 16'(swps[c].e1));
         chk($sformatf("sweep%0d_rd2", c + 1), 16'(a_rd2), 16'(swps[c].e2));
         chk($sformatf("sweep%0d_busy", c + 1), 16'(a_busy), 16'(swps[c].busy));
         chk($sformatf("sweep%0d_done", c + 1), 16'(a_done), 16'(swps[c].done));
         cyc();
      end
      reg_write = 1'b0;

      // Clear held high: sweep, done, idle, and a fresh sweep
      clear = 1'b1;
      cyc();
      for (int c = 1; c <= 12; c++) begin
         #1;
         chk($sformatf("hold%0d_busy", c), 16'(a_busy),
             ((c % 6) >= 1 && (c % 6) <= 4) ? 16'h0001 : 16'h0000);
         chk($sformatf("hold%0d_done", c), 16'(a_done),
             ((c % 6) == 5) ? 16'h0001 : 16'h0000);
         if (c == 12) clear = 1'b0;
         cyc();
      end

      // Reset asserted two cycles into a sweep
      reg_write = 1'b1; write_r = 2'd3; write_d = 8'hCC;
      cyc();
      reg_write = 1'b0;
      clear     = 1'b1;
      cyc();
      clear = 1'b0;
      cyc();
      cyc();
      read1 = 2'd3;
      read2 = 2'd2;
      #1;
      chk("midrst_pre_busy", 16'(a_busy), 16'h0001);
      chk("midrst_pre_rd1", 16'(a_rd1), 16'h00CC);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 16'(a_busy), 16'h0000);
      chk("midrst_done", 16'(a_done), 16'h0000);
      chk("midrst_rd1", 16'(a_rd1), 16'h0000);
      chk("midrst_rd2", 16'(a_rd2), 16'h0000);
      chk("midrst_z_busy", 16'(z_busy), 16'h0000);
      rst_n     = 1'b1;
      reg_write = 1'b1; write_r = 2'd3; write_d = 8'h12;
      #1;
      chk("postrst_bypass", 16'(a_rd1), 16'h0012);
      cyc();
      reg_write = 1'b0;
      #1;
      chk("postrst_rd1", 16'(a_rd1), 16'h0012);
      chk("postrst_busy", 16'(a_busy), 16'h0000);
      cyc();

      // 16-bit x 8 instance: full sweep clears r7
      w_we = 1'b1; w_wr = 3'd7; w_wd = 16'hBEEF;
      cyc();
      w_we = 1'b0;
      w_r1 = 3'd7;
      #1;
      chk("wide_rd_beef", w_rd1, 16'hBEEF);
      w_clear = 1'b1;
      cyc();
      w_clear  = 1'b0;
      busy_cnt = 0;
      done_cnt = 0;
      done_at  = 0;
      for (int c = 1; c <= 12; c++) begin
         #1;
         if (w_busy) busy_cnt++;
         if (w_done) begin
            done_cnt++;
            done_at = c;
         end
         cyc();
      end
      chk("wide_busy_cycles", 16'(busy_cnt), 16'd8);
      chk("wide_done_cycles", 16'(done_cnt), 16'd1);
      chk("wide_done_at", 16'(done_at), 16'd9);
      #1;
      chk("wide_rd_cleared", w_rd1, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_regfile_param

// File: doc/regfile_param.md
# regfile_param

Parametrised multi-port register file for the microprocessor datapath, successor to the fixed 4×8-bit two-read/one-write register bank. Adds configurable width and depth, optional hardwired-zero register 0, optional write-to-read bypass, and a sequenced bulk-clear operation with a Busy/Done handshake. Sits between instruction decode (register addresses) and the ALU/writeback mux.

## Interface
- WIDTH, 8: data width of each register.
- ADDR_W, 2: address width; DEPTH = 2**ADDR_W registers.
- ZERO_REG, 0: 1 = register 0 always reads 0 and ignores writes.
- BYPASS, 1: 1 = same-cycle write data forwarded to matching read ports.
- clk  in  1  sole clock, rising edge.
- Reset_n  in  1  reset, asynchronous and active-low.
- RegWrite  in  1  write enable for WriteR/WriteD.
- Read1  in  ADDR_W  read port 1 address.
- Read2  in  ADDR_W  read port 2 address.
- WriteR  in  ADDR_W  write address.
- WriteD  in  WIDTH  write data.
- ReadD1  out  WIDTH  read port 1 data.
- ReadD2  out  WIDTH  read port 2 data.
- Clear  in  1  request bulk clear of all registers.
- Busy  out  1  high while the clear sweep runs.
- Done  out  1  one-cycle pulse when the sweep completes.

## Operation
- States: IDLE, SWEEP, DONE. Sweep index idx, ADDR_W bits.
- IDLE: RegWrite=1 writes WriteD into reg[WriteR] at the edge. Clear=1 → SWEEP, idx=0.
- SWEEP: each edge writes 0 to reg[idx] and increments idx; at idx==DEPTH-1 the clear is applied and the state moves to DONE. RegWrite is ignored (dropped, not queued). Clear is ignored.
- DONE: Done=1 for one cycle; RegWrite accepted as in IDLE; Clear ignored; → IDLE.
- Simultaneous Clear and RegWrite in IDLE: the write is performed and the sweep starts. The written register is later cleared by the sweep.
- Reads are combinational in all states: ReadDn = reg[Readn].
  - BYPASS=1 and a write is accepted this cycle with WriteR==Readn: ReadDn = WriteD.
  - Clear-sweep writes are never bypassed.
- ZERO_REG=1: reads of address 0 return 0, including under bypass. Writes to address 0 are discarded.
- Both read ports may address the same register or the write register. No port conflicts exist.

## Timing
- Reset_n low (async): all registers 0, state IDLE, idx 0, Busy 0, Done 0. ReadD1/ReadD2 = 0.
- Reset mid-sweep: the sweep is abandoned and all registers are 0 immediately.
- Write latency: visible on reads the cycle after the edge; same cycle when BYPASS=1.
- Clear sampled at edge T0:
  - Busy=1 from T0 to T(DEPTH).
  - reg[k] cleared at edge T(k+1).
  - Done=1 between T(DEPTH) and T(DEPTH+1).
  - Total DEPTH+1 cycles back to IDLE.
- Clear held high continuously: a new sweep starts from IDLE after each DONE.

## Structure
- Package regfile_pkg holds:
  - state encoding constants (IDLE=2'd0, SWEEP=2'd1, DONE=2'd2);
  - default WIDTH/ADDR_W constants shared with the decode and ALU blocks.
- Storage is an array of DEPTH×WIDTH flops, written through one write-address decoder.
- Sub-module regfile_clear_fsm contains the state register, idx counter, Busy/Done, and a write-accept output. The top level muxes sweep-zero writes against user writes.

## Test plan
- Reset, then write 8'hA5→r1 and 8'h3C→r2; read Read1=1, Read2=2 next cycle → ReadD1=A5, ReadD2=3C.
- BYPASS=1: RegWrite r3=8'h7E with Read1=3 in the same cycle → ReadD1=7E before the edge. With BYPASS=0 → old value 00.
- ZERO_REG=1: write 8'hFF→r0 → ReadD1 (Read1=0) stays 00, including the bypass cycle.
- Fill r0..r3 with 11/22/33/44, pulse Clear:
  - Busy high 4 cycles, then Done for 1 cycle;
  - r0..r3 read 00 in order, one per cycle;
  - RegWrite r2=55 issued mid-sweep is dropped.
- Assert Reset_n low two cycles into a sweep → Busy/Done 0 immediately, all reads 00, state IDLE. A subsequent write works normally.
- WIDTH=16, ADDR_W=3: write 16'hBEEF→r7, run a full sweep → Busy 8 cycles, r7 reads 0000 after Done.
